// File: rtl/boot_pkg.sv
// Shared state encoding and image-format constants for the boot loader.
package boot_pkg;
   typedef enum logic [2:0] {HOLD, LEN0, LEN1, DATA, WRITE, RUN, ERROR} boot_state_t;
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/boot_loader_word_packer.sv
// Assembles little-endian bytes into an instruction word; updates on the load edge.
// Never stalls: accepts a byte on every load, o_last_byte flags the fourth byte.
module word_packer
   import boot_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_load,
   input  logic                    i_clear,
   input  logic [7:0]              i_byte,
   output logic [WORD_BYTES*8-1:0] o_word,
   output logic                    o_last_byte
);
   logic [1:0]              r_idx;
   logic [WORD_BYTES*8-1:0] r_word;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_load) begin
         r_word[{r_idx, 3'b000} +: 8] <= i_byte;
         r_idx                        <= r_idx + 2'd1;
      end
   end

   assign o_word      = r_word;
   assign o_last_byte = (r_idx == 2'(WORD_BYTES - 1));
endmodule

// File: rtl/boot_loader.sv
// Holds the core in reset while a length-prefixed image is streamed into IMEM, then releases it.
// One IMEM write cycle per 4 accepted bytes (peak 1 word / 5 cycles); rx_ready only in LEN0/LEN1/DATA.
module boot_loader
   import boot_pkg::*;
#(
   parameter  int data_size    = 1024,
   parameter  int address_size = 32,
   localparam int AW           = $clog2(data_size)
)(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    load_req,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic                    imem_we,
   output logic [AW-1:0]           imem_waddr,
   output logic [address_size-1:0] imem_wdata,
   output logic                    core_rst_n,
   output logic                    busy,
   output logic                    err
);
   boot_state_t             r_state, w_next;
   logic [8*LEN_BYTES-1:0]  r_len;
   logic [AW:0]             r_cnt;
   logic [AW-1:0]           r_waddr;
   logic [address_size-1:0] r_wdata;
   logic                    r_core_rst_n;
   logic                    w_start, w_accept, w_last_byte, w_last_word;
   logic [8*LEN_BYTES-1:0]  w_len_n;
   logic [WORD_BYTES*8-1:0] w_word;

   assign w_start     = load_req && (r_state == HOLD || r_state == RUN || r_state == ERROR);
   assign w_accept    = rx_valid && rx_ready;
   assign w_len_n     = {rx_data, r_len[7:0]};
   // Counter is one bit wider than the address so a full-depth image ends cleanly.
   assign w_last_word = (32'(r_cnt) == 32'(r_len) - 32'd1);

   word_packer u_packer (
      .i_clk       (CLK),
      .i_rst       (RESET),
      .i_load      (w_accept && r_state == DATA),
      .i_clear     (w_start),
      .i_byte      (rx_data),
      .o_word      (w_word),
      .o_last_byte (w_last_byte)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= HOLD;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         HOLD, RUN, ERROR: if (load_req) w_next = LEN0;
         LEN0:  if (w_accept) w_next = LEN1;
         LEN1: begin
            if (w_accept) begin
               if (w_len_n == '0)                          w_next = RUN;
               else if (32'(w_len_n) > 32'(data_size))     w_next = ERROR;
               else                                        w_next = DATA;
            end
         end
         DATA:  if (w_accept && w_last_byte) w_next = WRITE;
         WRITE: w_next = w_last_word ? RUN : DATA;
         default: w_next = HOLD;
      endcase
   end

   always_comb begin
      rx_ready = 1'b0;
      imem_we  = 1'b0;
      busy     = 1'b0;
      err      = 1'b0;
      case (r_state)
         LEN0, LEN1, DATA: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         WRITE: begin
            imem_we = 1'b1;
            busy    = 1'b1;
         end
         ERROR:   err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_len        <= '0;
         r_cnt        <= '0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_core_rst_n <= 1'b0;
      end else begin
         // Registered from next state so it tracks (state == RUN) without extra delay.
         r_core_rst_n <= (w_next == RUN);
         if (w_start) r_cnt <= '0;
         if (w_accept && r_state == LEN0) r_len[7:0]  <= rx_data;
         if (w_accept && r_state == LEN1) r_len[15:8] <= rx_data;
         if (w_accept && r_state == DATA && w_last_byte) r_waddr <= r_cnt[AW-1:0];
         if (r_state == WRITE) begin
            r_wdata <= address_size'(w_word);
            if (!w_last_word) r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // The packer holds the complete word only during WRITE; afterwards the captured copy holds.
   assign imem_wdata = (r_state == WRITE) ? address_size'(w_word) : r_wdata;
   assign imem_waddr = r_waddr;
   assign core_rst_n = r_core_rst_n;
endmodule

// File: doc/boot_loader.md
# boot_loader

Boot sequencer for the single-cycle RISC-V core. It holds the core in reset, receives a program image as a byte stream over a valid/ready handshake, and writes it word-by-word into instruction memory through the IMEM write port. It then releases the core's `RESET_N`, and can reload the image on request. It sits between the host link (UART receiver or testbench) and the `core`/IMEM pair at top level.

## Interface
Parameters:
- `data_size`, default 1024: IMEM depth in 32-bit words; `AW = $clog2(data_size)`.
- `address_size`, default 32: IMEM word width in bits.

Ports:
- `CLK` — in, 1 — the single clock; all state updates on its rising edge.
- `RESET` — in, 1 — asynchronous, active-high reset.
- `load_req` — in, 1 — one-cycle pulse; starts an image load and is legal in `HOLD`, `RUN` and `ERROR`.
- `rx_data` — in, 8 — byte from the host link.
- `rx_valid` — in, 1 — `rx_data` valid.
- `rx_ready` — out, 1 — loader accepts a byte this cycle.
- `imem_we` — out, 1 — IMEM write strobe.
- `imem_waddr` — out, AW — IMEM word address.
- `imem_wdata` — out, address_size — assembled instruction word.
- `core_rst_n` — out, 1 — drives `core.RESET_N`; 0 holds the core.
- `busy` — out, 1 — high from `LEN0` through `WRITE`.
- `err` — out, 1 — image length invalid.

## Operation
- FSM states: `HOLD`, `LEN0`, `LEN1`, `DATA`, `WRITE`, `RUN`, `ERROR`. Reset enters `HOLD`.
- **Byte accept:** a byte is accepted on a rising edge with `rx_valid & rx_ready`.
- **`rx_ready`:** high only in `LEN0`, `LEN1` and `DATA`.
- **Image format:** 16-bit word count N, sent little-endian (`LEN0` = low byte, `LEN1` = high byte). This is followed by N words of 4 bytes each, little-endian: first byte → `[7:0]`, fourth byte → `[31:24]`.
- **State transitions:**
  - `HOLD`/`RUN`/`ERROR` + `load_req` → `LEN0`. Byte index and word counter are cleared.
  - `LEN0` + accept → `LEN1`.
  - `LEN1` + accept:
    - N == 0 → `RUN`.
    - N > data_size → `ERROR`.
    - Otherwise → `DATA`.
  - `DATA` + accept with byte index == 3 → `WRITE`. Otherwise the byte index increments and the state stays `DATA`.
  - `WRITE`: `imem_we` is high for exactly one cycle with `imem_waddr` = word counter and `imem_wdata` = packed word. Then:
    - Word counter == N−1 → `RUN`.
    - Otherwise the counter increments and the state returns to `DATA`.
- **`core_rst_n`:** registered, equal to (state == `RUN`). It is 0 in every other state, so `load_req` while running re-asserts core reset from the next cycle.
- **`err`:** high only in `ERROR`; cleared on leaving it.
- **Outside `WRITE`:** `imem_we` = 0, and `imem_waddr`/`imem_wdata` hold their last values.
- **Ignored inputs:**
  - `load_req` during `LEN0`..`WRITE` is ignored (no restart mid-load).
  - `rx_valid` is ignored when `rx_ready` = 0.
- **Address width:** the word counter is AW+1 bits, so N == data_size is legal. It fills addresses 0..data_size−1, and the counter never wraps into address 0.

## Timing
- **Reset values:** `rx_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `core_rst_n`=0, `busy`=0, `err`=0.
- `RESET` asserted mid-load aborts immediately (asynchronous): state → `HOLD`, core held, partially written IMEM contents left as-is.
- **Load throughput:** the 4th byte accepted at edge k gives `imem_we`=1 during cycle k+1. The next byte can be accepted at edge k+2. Peak throughput is one word per 5 cycles.
- **Release latency:** `core_rst_n` rises the cycle after the edge that enters `RUN`:
  - last `WRITE` cycle + 1, or
  - `LEN1` accept + 1 when N = 0.
- `load_req` in `RUN` at edge k: `core_rst_n` = 0 and `rx_ready` = 1 from cycle k+1.
- `load_req` and `rx_valid` in the same cycle in `HOLD`: the byte is not accepted, because `rx_ready` was 0.

## Structure
- Package `boot_pkg`:
  - `boot_state_t` enum (the 7 states).
  - `LEN_BYTES` = 2, `WORD_BYTES` = 4.
- One sub-module, `word_packer`:
  - shift-in byte register with 2-bit index;
  - inputs: `load`, `clear`, byte;
  - outputs: 32-bit word and `last_byte` flag.
- The FSM, word counter and length register stay in `boot_loader`.

## Test plan
- **Reset:** assert `RESET` → all outputs at reset values and state `HOLD`; `rx_valid`=1 with `load_req`=0 → no accept.
- **Two-word load:** `load_req`, bytes 02 00, 13 05 A0 00, 93 05 15 00 → writes 0x00A00513 @0 and 0x00150593 @1; `core_rst_n`=1 one cycle after the 2nd write.
- **Backpressure:** `rx_valid` toggled randomly during the 2-word load → identical writes; `imem_we` pulses exactly twice, 1 cycle each.
- **Boundary lengths:**
  - N=0 → `RUN` with no writes.
  - N=1025 (01 04) → `err`=1, `core_rst_n` stays 0, then `load_req` clears `err`.
  - N=1024 → last write to address 1023.
- **Reload from `RUN`:** `load_req` → `core_rst_n` falls next cycle; new image of 1 word → written @0, core re-released.
- **Abort:** `RESET` pulse after the 3rd data byte → `imem_we` never asserted for that word, state `HOLD`, `core_rst_n`=0.
